// File: rtl/baud_pkg.sv
// Shared baud-rate definitions: rate table, select constants and the divisor calculation.
package baud_pkg;

  localparam int BAUD_SEL_W = 4;
  localparam int BAUD_NUM   = 12;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_MAX = 4'hB;

  typedef logic [BAUD_SEL_W-1:0] baud_sel_t;

  typedef enum logic [BAUD_SEL_W-1:0] {
    B300    = 4'd0,
    B1200   = 4'd1,
    B2400   = 4'd2,
    B4800   = 4'd3,
    B9600   = 4'd4,
    B19200  = 4'd5,
    B38400  = 4'd6,
    B57600  = 4'd7,
    B115200 = 4'd8,
    B230400 = 4'd9,
    B460800 = 4'd10,
    B921600 = 4'd11
  } baud_idx_e;

  localparam int unsigned BAUD_RATE [BAUD_NUM] = '{
    300, 1200, 2400, 4800, 9600, 19200,
    38400, 57600, 115200, 230400, 460800, 921600
  };

  // round(clk_hz / (rate*os)) with ties rounded up, never below 2
  function automatic int unsigned calc_div(longint unsigned clk_hz,
                                           longint unsigned rate,
                                           longint unsigned os);
    longint unsigned d;
    longint unsigned q;
    d = rate * os;
    q = (2 * clk_hz + d) / (2 * d);
    if (q < 2) q = 2;
    return int'(q);
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/tick bundle between the UART engines (master) and baud_tick_gen (slave).
// Override signals exist only when BAUD_OVERRIDE_EN is defined.
interface baud_tick_gen_if
  import baud_pkg::*;
#(
  parameter int DIV_W = 19
);
  logic             enable;
  logic             restart;
  baud_sel_t        baud_sel;
  logic             os_tick;
  logic             mid_tick;
  logic             bit_tick;
  logic [DIV_W-1:0] div_out;
  logic             sel_valid;
`ifdef BAUD_OVERRIDE_EN
  logic             div_override_en;
  logic [DIV_W-1:0] div_override;

  modport master (
    output enable, restart, baud_sel, div_override_en, div_override,
    input  os_tick, mid_tick, bit_tick, div_out, sel_valid
  );
  modport slave (
    input  enable, restart, baud_sel, div_override_en, div_override,
    output os_tick, mid_tick, bit_tick, div_out, sel_valid
  );
`else
  modport master (
    output enable, restart, baud_sel,
    input  os_tick, mid_tick, bit_tick, div_out, sel_valid
  );
  modport slave (
    input  enable, restart, baud_sel,
    output os_tick, mid_tick, bit_tick, div_out, sel_valid
  );
`endif
endinterface

// File: rtl/baud_div_counter.sv
// Cycle and oversample counters producing registered os/mid/bit ticks.
module baud_div_counter
  import baud_pkg::*;
#(
  parameter int DIV_W      = 19,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_os_tick,
  output logic             o_mid_tick,
  output logic             o_bit_tick
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  // OVERSAMPLE = 1 has no bit centre, so mid_tick stays low
  localparam logic HAS_MID = (OVERSAMPLE >= 2);
  localparam logic [OS_W-1:0] OS_MID = HAS_MID ? OS_W'(OVERSAMPLE / 2 - 1) : '0;

  logic [DIV_W-1:0] r_cyc;
  logic [OS_W-1:0]  r_os;
  logic             r_os_tick;
  logic             r_mid_tick;
  logic             r_bit_tick;
  logic             w_tc;

  assign w_tc = (r_cyc == i_div - DIV_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc      <= '0;
      r_os       <= '0;
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (!i_enable || i_clear) begin
      r_cyc      <= '0;
      r_os       <= '0;
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (w_tc) begin
      r_cyc      <= '0;
      r_os       <= (r_os == OS_LAST) ? '0 : r_os + OS_W'(1);
      r_os_tick  <= 1'b1;
      r_mid_tick <= HAS_MID && (r_os == OS_MID);
      r_bit_tick <= (r_os == OS_LAST);
    end else begin
      r_cyc      <= r_cyc + DIV_W'(1);
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end
  end

  assign o_os_tick  = r_os_tick;
  assign o_mid_tick = r_mid_tick;
  assign o_bit_tick = r_bit_tick;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator top: select register, divisor table/override and change detect.
// Optional runtime divisor override when BAUD_OVERRIDE_EN is defined.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter longint unsigned CLK_HZ     = 100_000_000,
  parameter int              OVERSAMPLE = 16,
  parameter int              DIV_W      = 19
) (
  input  logic           clk,
  input  logic           reset,
  baud_tick_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_RST =
    DIV_W'(calc_div(CLK_HZ, longint'(BAUD_RATE[0]), longint'(OVERSAMPLE)));

  logic [DIV_W-1:0] w_tab [BAUD_NUM];
  baud_sel_t        r_sel;
  baud_idx_e        w_idx;
  logic             w_sel_ok;
  logic             w_sel_valid;
  logic [DIV_W-1:0] w_div_tab;
  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] r_div;
  logic             w_ovr_chg;
  logic             w_change;
  logic             w_clear;

  for (genvar g = 0; g < BAUD_NUM; g++) begin : g_tab
    assign w_tab[g] =
      DIV_W'(calc_div(CLK_HZ, longint'(BAUD_RATE[g]), longint'(OVERSAMPLE)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sel <= '0;
    else       r_sel <= bus.baud_sel;
  end

  // out-of-range selects fall back to the 300 baud entry
  assign w_sel_ok  = (r_sel <= BAUD_SEL_MAX);
  assign w_idx     = w_sel_ok ? baud_idx_e'(r_sel) : B300;
  assign w_div_tab = w_tab[w_idx];

`ifdef BAUD_OVERRIDE_EN
  logic             r_ovr_en;
  logic             r_ovr_en_q;
  logic [DIV_W-1:0] r_ovr;
  logic [DIV_W-1:0] r_ovr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr_en   <= 1'b0;
      r_ovr_en_q <= 1'b0;
      r_ovr      <= '0;
      r_ovr_q    <= '0;
    end else begin
      r_ovr_en   <= bus.div_override_en;
      r_ovr_en_q <= r_ovr_en;
      r_ovr      <= bus.div_override;
      r_ovr_q    <= r_ovr;
    end
  end

  assign w_div       = r_ovr_en ? ((r_ovr < DIV_W'(2)) ? DIV_W'(2) : r_ovr) : w_div_tab;
  assign w_ovr_chg   = (r_ovr_en != r_ovr_en_q) || (r_ovr != r_ovr_q);
  assign w_sel_valid = r_ovr_en | w_sel_ok;
`else
  assign w_div       = w_div_tab;
  assign w_ovr_chg   = 1'b0;
  assign w_sel_valid = w_sel_ok;
`endif

  // a select change that maps to the same divisor leaves the counters running
  assign w_change = (w_div != r_div) || w_ovr_chg;
  assign w_clear  = w_change || bus.restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_div <= DIV_RST;
    else if (w_change) r_div <= w_div;
  end

  baud_div_counter #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (bus.enable),
    .i_clear    (w_clear),
    .i_div      (r_div),
    .o_os_tick  (bus.os_tick),
    .o_mid_tick (bus.mid_tick),
    .o_bit_tick (bus.bit_tick)
  );

  assign bus.div_out   = r_div;
  assign bus.sel_valid = w_sel_valid;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen against a timestamp-based reference model.
module tb_baud_tick_gen;

  localparam longint CLK_HZ = 100_000_000;
  localparam int     OS     = 16;
  localparam int     DIV_W  = 19;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  baud_tick_gen_if #(.DIV_W(DIV_W)) bus ();

  baud_tick_gen #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OS),
    .DIV_W      (DIV_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int rates [12] = '{300, 1200, 2400, 4800, 9600, 19200,
                     38400, 57600, 115200, 230400, 460800, 921600};

  int errors = 0;
  int checks = 0;

  // model: ticks fall on edges anchor + k*div, anchor = last edge that forced the counters to 0
  int               n = 0;
  int               m_anchor;
  int               m_div;
  logic [3:0]       m_sel_q;
  logic             m_oen, m_oen_q;
  logic [DIV_W-1:0] m_ov, m_ov_q;
  logic             e_os, e_mid, e_bit, e_sv;
  logic [DIV_W-1:0] e_div;

  function automatic int ref_div(int rate);
    real x;
    int  k;
    x = real'(CLK_HZ) / (real'(rate) * OS);
    k = $rtoi(x + 0.5);
    if (k < 2) k = 2;
    return k;
  endfunction

  function automatic int want_div(logic [3:0] s, logic oen, logic [DIV_W-1:0] ov);
    if (oen) return (ov < 2) ? 2 : int'(ov);
    return ref_div(rates[(s > 4'd11) ? 0 : int'(s)]);
  endfunction

  task automatic model_reset();
    m_sel_q = 4'd0;
    m_div   = ref_div(rates[0]);
    m_oen   = 1'b0; m_oen_q = 1'b0;
    m_ov    = '0;   m_ov_q  = '0;
    m_anchor = n;
    e_os = 0; e_mid = 0; e_bit = 0; e_sv = 1;
    e_div = DIV_W'(m_div);
  endtask

  // predict the outputs after the next clock edge from the inputs now applied, then advance
  task automatic cycle();
    int               w, k, idx;
    bit               chg, forced;
    logic             oen_in;
    logic [DIV_W-1:0] ov_in;
    oen_in = 1'b0;
    ov_in  = '0;
`ifdef BAUD_OVERRIDE_EN
    oen_in = bus.div_override_en;
    ov_in  = bus.div_override;
`endif
    n++;
    w   = want_div(m_sel_q, m_oen, m_ov);
    chg = (w != m_div) || (m_oen != m_oen_q) || (m_ov != m_ov_q);
    if (chg) m_div = w;
    forced = !bus.enable || bus.restart || chg;
    e_os = 0; e_mid = 0; e_bit = 0;
    if (forced) m_anchor = n;
    else begin
      k = n - m_anchor;
      if (k % m_div == 0) begin
        idx   = k / m_div;
        e_os  = 1;
        e_bit = (idx % OS) == 0;
        e_mid = (idx % OS) == OS / 2;
      end
    end
    m_sel_q = bus.baud_sel;
    m_oen_q = m_oen; m_oen = oen_in;
    m_ov_q  = m_ov;  m_ov  = ov_in;
    e_div = DIV_W'(m_div);
    e_sv  = m_oen ? 1'b1 : (m_sel_q <= 4'd11);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset(string tag);
    bus.enable = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== 4'b0001 ||
        bus.div_out !== DIV_W'(ref_div(rates[0]))) begin
      errors++;
      $display("FAIL %s ticks/sv=%b req=0001 div=%0d req=%0d", tag,
               {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
               bus.div_out, ref_div(rates[0]));
    end
    bus.enable  = 1'b0;
    bus.restart = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sel9_periods();
    int d, last_os, last_bit, last_mid, os_gap, bit_gap, mid_lead;
    d = ref_div(rates[9]);
    last_os = -1; last_bit = -1; last_mid = -1; os_gap = -1; bit_gap = -1; mid_lead = -1;
    bus.baud_sel = 4'd9;
    bus.enable   = 1'b1;
    repeat (2 * OS * d + 3 * d) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL sel9 n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
      if (bus.os_tick) begin if (last_os >= 0) os_gap = n - last_os; last_os = n; end
      if (bus.mid_tick) last_mid = n;
      if (bus.bit_tick) begin
        if (last_bit >= 0) bit_gap = n - last_bit;
        last_bit = n;
        if (last_mid >= 0) mid_lead = n - last_mid;
      end
    end
    checks++;
    if (os_gap != d) begin errors++; $display("FAIL os_period got=%0d req=%0d", os_gap, d); end
    checks++;
    if (bit_gap != OS * d) begin errors++; $display("FAIL bit_period got=%0d req=%0d", bit_gap, OS * d); end
    checks++;
    if (mid_lead != OS / 2 * d) begin errors++; $display("FAIL mid_lead got=%0d req=%0d", mid_lead, OS / 2 * d); end
  endtask

  task automatic test_sel0_vs_e();
    bus.enable   = 1'b1;
    bus.baud_sel = 4'd0;
    repeat (5) cycle();
    checks++;
    if (bus.div_out !== DIV_W'(ref_div(300)) || bus.sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL sel0 div=%0d req=%0d sv=%b req=1", bus.div_out, ref_div(300), bus.sel_valid);
    end
    bus.baud_sel = 4'hE;
    repeat (20840) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL selE n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
    end
    checks++;
    if (bus.div_out !== DIV_W'(ref_div(300)) || bus.sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL selE_final div=%0d req=%0d sv=%b req=0", bus.div_out, ref_div(300), bus.sel_valid);
    end
  endtask

  task automatic test_restart();
    int d, first_os, first_bit;
    bit found;
    d = ref_div(rates[9]);
    bus.baud_sel = 4'd9;
    bus.enable   = 1'b1;
    found = 0;
    for (int i = 0; i < OS * d + 20 && !found; i++) begin
      cycle();
      found = bus.bit_tick;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL restart_wait no bit_tick req=1"); end
    repeat (99) cycle();
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
    checks++;
    if ({bus.os_tick, bus.mid_tick, bus.bit_tick} !== 3'b000) begin
      errors++;
      $display("FAIL restart_cycle ticks=%b req=000", {bus.os_tick, bus.mid_tick, bus.bit_tick});
    end
    first_os = -1; first_bit = -1;
    for (int c = 1; c <= OS * d; c++) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL restart n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
      if (bus.os_tick && first_os < 0) first_os = c;
      if (bus.bit_tick && first_bit < 0) first_bit = c;
    end
    checks++;
    if (first_os != d) begin errors++; $display("FAIL restart_os got=%0d req=%0d", first_os, d); end
    checks++;
    if (first_bit != OS * d) begin errors++; $display("FAIL restart_bit got=%0d req=%0d", first_bit, OS * d); end
    // next edge after d-1 cycles is a terminal count: restart must win
    repeat (d - 1) cycle();
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
    checks++;
    if (bus.os_tick !== 1'b0 || e_os !== 1'b0) begin
      errors++;
      $display("FAIL restart_vs_tc os=%b model=%b req=0", bus.os_tick, e_os);
    end
  endtask

  task automatic test_enable_gap();
    int d, ticks_low, first_os;
    d = ref_div(rates[9]);
    repeat (200) cycle();
    bus.enable = 1'b0;
    ticks_low = 0;
    repeat (500) begin
      cycle();
      if (bus.os_tick || bus.mid_tick || bus.bit_tick) ticks_low++;
    end
    checks++;
    if (ticks_low != 0) begin errors++; $display("FAIL enable_low ticks=%0d req=0", ticks_low); end
    bus.enable = 1'b1;
    first_os = -1;
    for (int c = 1; c <= d + 5 && first_os < 0; c++) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL enable_rise n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
      if (bus.os_tick) first_os = c;
    end
    checks++;
    if (first_os != d) begin errors++; $display("FAIL enable_first_os got=%0d req=%0d", first_os, d); end
  endtask

  task automatic test_sel_change();
    int d9, db, last_os, os_gap;
    d9 = ref_div(rates[9]);
    db = ref_div(rates[11]);
    repeat (150) cycle();
    bus.baud_sel = 4'hB;
    cycle();
    checks++;
    if (bus.div_out !== DIV_W'(d9)) begin errors++; $display("FAIL selB_1clk div=%0d req=%0d", bus.div_out, d9); end
    cycle();
    checks++;
    if (bus.div_out !== DIV_W'(db) || bus.os_tick !== 1'b0) begin
      errors++;
      $display("FAIL selB_2clk div=%0d req=%0d os=%b req=0", bus.div_out, db, bus.os_tick);
    end
    last_os = -1; os_gap = -1;
    repeat (2 * OS * db + 5) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL selB n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
      if (bus.os_tick) begin if (last_os >= 0) os_gap = n - last_os; last_os = n; end
    end
    checks++;
    if (os_gap != db) begin errors++; $display("FAIL selB_period got=%0d req=%0d", os_gap, db); end
  endtask

`ifdef BAUD_OVERRIDE_EN
  task automatic test_override();
    int last_os, os_gap;
    bus.div_override    = DIV_W'(1);
    bus.div_override_en = 1'b1;
    repeat (3) cycle();
    checks++;
    if (bus.div_out !== DIV_W'(2) || bus.sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_div div=%0d req=2 sv=%b req=1", bus.div_out, bus.sel_valid);
    end
    last_os = -1; os_gap = -1;
    repeat (40) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL ovr n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
      if (bus.os_tick) begin if (last_os >= 0) os_gap = n - last_os; last_os = n; end
    end
    checks++;
    if (os_gap != 2) begin errors++; $display("FAIL ovr_period got=%0d req=2", os_gap); end
    bus.div_override_en = 1'b0;
    repeat (50) begin
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL ovr_off n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
    end
    checks++;
    if (bus.div_out !== DIV_W'(ref_div(rates[11]))) begin
      errors++;
      $display("FAIL ovr_restore div=%0d req=%0d", bus.div_out, ref_div(rates[11]));
    end
  endtask
`endif

  task automatic test_random();
    int r;
    repeat (4000) begin
      r = int'($urandom_range(0, 999));
      bus.restart = (r < 30);
      if (r >= 990) bus.enable = ~bus.enable;
      else if (r >= 980) bus.baud_sel = 4'($urandom_range(7, 15));
      cycle();
      checks++;
      if ({bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid} !== {e_os, e_mid, e_bit, e_sv} ||
          bus.div_out !== e_div) begin
        errors++;
        $display("FAIL random n=%0d ticks/sv=%b req=%b div=%0d req=%0d", n,
                 {bus.os_tick, bus.mid_tick, bus.bit_tick, bus.sel_valid},
                 {e_os, e_mid, e_bit, e_sv}, bus.div_out, e_div);
      end
    end
    bus.restart = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.restart  = 1'b0;
    bus.baud_sel = 4'd0;
`ifdef BAUD_OVERRIDE_EN
    bus.div_override_en = 1'b0;
    bus.div_override    = '0;
`endif
    @(negedge clk);
    test_reset("reset");
    test_sel9_periods();
    test_reset("reset_mid");
    test_sel0_vs_e();
    test_restart();
    test_enable_gap();
    test_sel_change();
`ifdef BAUD_OVERRIDE_EN
    test_override();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
